// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, owner encodings and the
// byte-lane merge used by read-modify-write stores.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RMW_WR = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W_DEF        = 3;

    // Lanes with be set come from the store data, the rest keep the old word.
    function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                                input logic [31:0] wdata,
                                                input logic [31:0] rdata);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : rdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Two-way grant logic: LSU normally wins, but IF is forced through once it
// has watched STARVE_LIMIT consecutive LSU grants while requesting.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   if_req,
    input  logic   lsu_req,
    output logic   if_gnt,
    output logic   lsu_gnt,
    output owner_t winner
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             if_win;
    logic             lsu_win;

    assign if_win  = if_req && (!lsu_req || (starve_cnt == LIMIT));
    assign lsu_win = lsu_req && !if_win;
    assign if_gnt  = en && if_win;
    assign lsu_gnt = en && lsu_win;
    assign winner  = lsu_win ? OWN_LSU : OWN_IF;

    // The count only means "IF has been waiting", so any gap in if_req resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (lsu_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-wide, async-read/sync-write memory between IF and LSU,
// one transaction at a time, with read-modify-write for sub-word stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rsp_valid,
    output logic [31:0] if_rdata,
    output logic        if_fault,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [3:0]  lsu_be,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_fault,
    output logic        mem_rw,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_selected
);

    // Handshake: a requester holds req and its fields stable until gnt; gnt is
    // a one-cycle pulse in IDLE, and the response is a one-cycle rsp_valid
    // carrying rdata/fault, two or three cycles after gnt.

    state_t      state;
    owner_t      owner_q;
    owner_t      winner;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        arb_en;
    logic        acc_fault;
    logic        full_wr;
    logic        direct_rsp;
    logic        in_mem_phase;
    logic [31:0] acc_rdata;

    assign arb_en = (state == ST_IDLE) && rst_n;

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) u_prio (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .if_req (if_req),
        .lsu_req(lsu_req),
        .if_gnt (if_gnt),
        .lsu_gnt(lsu_gnt),
        .winner (winner)
    );

    assign acc_fault    = (addr_q[1:0] != 2'b00) || !mem_selected;
    assign full_wr      = we_q && (be_q == 4'hF);
    assign acc_rdata    = (acc_fault || we_q) ? 32'h0 : mem_read_data;
    assign direct_rsp   = acc_fault || !we_q || (be_q == 4'hF) || (be_q == 4'h0);
    assign in_mem_phase = (state == ST_ACCESS) || (state == ST_RMW_WR);
    assign mem_address  = in_mem_phase ? addr_q : 32'h0;

    // Write strobe is decoded from state so an async reset drops it at once.
    always_comb begin
        mem_rw         = 1'b0;
        mem_write_data = 32'h0;
        if ((state == ST_ACCESS) && full_wr && !acc_fault) begin
            mem_rw         = 1'b1;
            mem_write_data = wdata_q;
        end else if (state == ST_RMW_WR) begin
            mem_rw         = 1'b1;
            mem_write_data = merged_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            owner_q       <= OWN_IF;
            addr_q        <= '0;
            wdata_q       <= '0;
            merged_q      <= '0;
            be_q          <= '0;
            we_q          <= 1'b0;
            if_rsp_valid  <= 1'b0;
            if_rdata      <= '0;
            if_fault      <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rdata     <= '0;
            lsu_fault     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_gnt || lsu_gnt) begin
                        owner_q <= winner;
                        addr_q  <= lsu_gnt ? lsu_addr : if_addr;
                        we_q    <= lsu_gnt && lsu_we;
                        be_q    <= lsu_gnt ? lsu_be : 4'h0;
                        wdata_q <= lsu_gnt ? lsu_wdata : 32'h0;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (direct_rsp) begin
                        if (owner_q == OWN_IF) begin
                            if_rsp_valid <= 1'b1;
                            if_rdata     <= acc_rdata;
                            if_fault     <= acc_fault;
                        end else begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rdata     <= acc_rdata;
                            lsu_fault     <= acc_fault;
                        end
                        state <= ST_RESP;
                    end else begin
                        merged_q <= merge_bytes(be_q, wdata_q, mem_read_data);
                        state    <= ST_RMW_WR;
                    end
                end
                ST_RMW_WR: begin
                    // Only the LSU issues stores, so the response is always LSU's.
                    lsu_rsp_valid <= 1'b1;
                    lsu_rdata     <= '0;
                    lsu_fault     <= 1'b0;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if_rsp_valid  <= 1'b0;
                    if_rdata      <= '0;
                    if_fault      <= 1'b0;
                    lsu_rsp_valid <= 1'b0;
                    lsu_rdata     <= '0;
                    lsu_fault     <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word memory model behind it.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rsp_valid, if_fault;
    logic [31:0] if_rdata;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [3:0]  lsu_be = '0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        lsu_gnt, lsu_rsp_valid, lsu_fault;
    logic [31:0] lsu_rdata;
    logic        mem_rw;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_selected;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (mem_rw) mem[mem_address[9:2]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[9:2]];
    assign mem_selected  = (mem_address[31:28] == 4'h8);

    mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rsp_valid  (if_rsp_valid),
        .if_rdata      (if_rdata),
        .if_fault      (if_fault),
        .lsu_req       (lsu_req),
        .lsu_we        (lsu_we),
        .lsu_be        (lsu_be),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_gnt       (lsu_gnt),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rdata     (lsu_rdata),
        .lsu_fault     (lsu_fault),
        .mem_rw        (mem_rw),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .mem_selected  (mem_selected)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // One transaction; exp_wr_k is the cycle after gnt with the write strobe, 0 for none.
    task automatic xact(input string tag, input bit lsu, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_f, input int exp_lat,
                        input int exp_wr_k, input logic [31:0] exp_wr_data);
        bit got_gnt, other;
        int lat, wr_cnt, wr_k;
        logic [31:0] rd, wrd;
        logic f;
        got_gnt = 0; other = 0; lat = 0; wr_cnt = 0; wr_k = 0; rd = '0; wrd = '0; f = 1'b0;
        @(posedge clk); #1;
        if (lsu) begin
            lsu_req = 1'b1; lsu_we = we; lsu_be = be; lsu_addr = addr; lsu_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 0; i < 20 && !got_gnt; i++) begin
            @(negedge clk);
            if (lsu ? lsu_gnt : if_gnt) got_gnt = 1;
        end
        check({tag, "_gnt"}, 32'(got_gnt), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0; lsu_req = 1'b0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            @(negedge clk);
            if (mem_rw) begin wr_cnt++; wr_k = i; wrd = mem_write_data; end
            if (lsu ? if_rsp_valid : lsu_rsp_valid) other = 1;
            if (lsu ? lsu_rsp_valid : if_rsp_valid) begin
                lat = i;
                rd  = lsu ? lsu_rdata : if_rdata;
                f   = lsu ? lsu_fault : if_fault;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_fault"}, 32'(f), 32'(exp_f));
        check({tag, "_wrcnt"}, 32'(wr_cnt), (exp_wr_k != 0) ? 32'd1 : 32'd0);
        check({tag, "_wrcyc"}, 32'(wr_k), 32'(exp_wr_k));
        check({tag, "_wrdata"}, wrd, exp_wr_data);
        check({tag, "_other"}, 32'(other), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] seq;
        int         n_gnt;
        bit         saw_rsp;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_lsu_gnt", 32'(lsu_gnt), 32'd0);
        check("rst_rsp", {30'd0, if_rsp_valid, lsu_rsp_valid}, 32'd0);
        check("rst_rdata", if_rdata | lsu_rdata, 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_mem_wd", mem_write_data, 32'd0);

        preload(8'd4,  32'h11223344);
        preload(8'd8,  32'hDEADBEEF);
        preload(8'd9,  32'h01020304);
        preload(8'd12, 32'h12345678);

        // IF load, partial stores with RMW and read-back
        xact("if_ld",   0, 0, 4'h0, 32'h8000_0010, 32'h0, 32'h11223344, 0, 2, 0, 32'h0);
        xact("pst_0010", 1, 1, 4'b0010, 32'h8000_0020, 32'h0000AB00, 32'h0, 0, 3, 2, 32'hDEADABEF);
        xact("pst_rb",  1, 0, 4'h0, 32'h8000_0020, 32'h0, 32'hDEADABEF, 0, 2, 0, 32'h0);
        xact("pst_1001", 1, 1, 4'b1001, 32'h8000_0024, 32'hAABBCCDD, 32'h0, 0, 3, 2, 32'hAA0203DD);
        xact("pst9_rb", 0, 0, 4'h0, 32'h8000_0024, 32'h0, 32'hAA0203DD, 0, 2, 0, 32'h0);

        // faults: misaligned, unmapped, misaligned full store never writes
        xact("lsu_mis", 1, 0, 4'h0, 32'h8000_0022, 32'h0, 32'h0, 1, 2, 0, 32'h0);
        xact("if_unm",  0, 0, 4'h0, 32'h0000_1000, 32'h0, 32'h0, 1, 2, 0, 32'h0);
        xact("st_mis",  1, 1, 4'hF, 32'h8000_0002, 32'hFFFFFFFF, 32'h0, 1, 2, 0, 32'h0);

        // full store, empty store, read-backs
        xact("st_full", 1, 1, 4'hF, 32'h8000_0000, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'hCAFEF00D);
        xact("full_rb", 1, 0, 4'h0, 32'h8000_0000, 32'h0, 32'hCAFEF00D, 0, 2, 0, 32'h0);
        xact("st_be0",  1, 1, 4'h0, 32'h8000_0000, 32'hFFFFFFFF, 32'h0, 0, 2, 0, 32'h0);
        xact("be0_rb",  0, 0, 4'h0, 32'h8000_0000, 32'h0, 32'hCAFEF00D, 0, 2, 0, 32'h0);

        // starvation: both held, expect L L L L I L L L L I
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h8000_0010;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'h0; lsu_addr = 32'h8000_0020;
        seq = '0; n_gnt = 0;
        for (int i = 0; i < 200 && n_gnt < 10; i++) begin
            @(negedge clk);
            if (if_gnt || lsu_gnt) begin
                seq[n_gnt] = if_gnt;
                n_gnt++;
            end
        end
        check("starve_cnt", 32'(n_gnt), 32'd10);
        check("starve_seq", 32'(seq), 32'h210);
        @(posedge clk); #1;
        if_req = 1'b0; lsu_req = 1'b0;
        repeat (6) @(posedge clk);

        // reset during RMW_WR of a partial store
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0001;
        lsu_addr = 32'h8000_0030; lsu_wdata = 32'h000000AA;
        n_gnt = 0;
        for (int i = 0; i < 20 && n_gnt == 0; i++) begin
            @(negedge clk);
            if (lsu_gnt) n_gnt = 1;
        end
        check("rrst_gnt", 32'(n_gnt), 32'd1);
        @(posedge clk); #1;
        lsu_we = 1'b0; lsu_addr = 32'h8000_0010;
        @(negedge clk);
        @(negedge clk);
        check("rrst_pre_rw", 32'(mem_rw), 32'd1);
        check("rrst_pre_wd", mem_write_data, 32'h123456AA);
        rst_n = 1'b0;
        #1;
        check("rrst_rw", 32'(mem_rw), 32'd0);
        check("rrst_addr", mem_address, 32'd0);
        check("rrst_wd", mem_write_data, 32'd0);
        check("rrst_gnt_low", {30'd0, if_gnt, lsu_gnt}, 32'd0);
        check("rrst_rsp", {30'd0, if_rsp_valid, lsu_rsp_valid}, 32'd0);
        saw_rsp = 0;
        repeat (2) begin
            @(negedge clk);
            if (if_rsp_valid || lsu_rsp_valid || mem_rw) saw_rsp = 1;
        end
        check("rrst_quiet", 32'(saw_rsp), 32'd0);
        lsu_req = 1'b0;
        rst_n = 1'b1;
        saw_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (if_rsp_valid || lsu_rsp_valid) saw_rsp = 1;
        end
        check("rrst_no_rsp", 32'(saw_rsp), 32'd0);
        xact("rrst_rb", 1, 0, 4'h0, 32'h8000_0030, 32'h0, 32'h12345678, 0, 2, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
